// File: rtl/bin_to_bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// DIGITS    : number of BCD digits driven to the display bank
// BIN_W_DEF : default binary input width (covers 0..99,999,999)
// BCD_MAX   : largest value that fits in DIGITS decimal digits
// BCD_SAT   : all-nines pattern shown when the input is out of range
// state_e   : converter FSM states
package bin_to_bcd_pkg;

    localparam int          DIGITS    = 8;
    localparam int          BIN_W_DEF = 27;
    localparam logic [31:0] BCD_MAX   = 32'd99_999_999;
    localparam logic [31:0] BCD_SAT   = 32'h9999_9999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
// din  : current 4-bit scratch digit
// dout : corrected digit (din + 3 when din >= 5, else din)
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds the 8-digit seven-segment bank; the previous result stays on the
// outputs until a new conversion finishes, so the displays never flicker.
// iCLK   : clock, rising edge
// iRST_N : synchronous active-low reset
// iBIN   : unsigned binary value, sampled on an accepted start
// iSTART : conversion request, accepted only in IDLE
// oBCD   : packed BCD result, digit i in bits [4i+3:4i]
// oBLANK : leading-zero blank mask, 1 = blank digit i (digit 0 never blank)
// oBUSY  : high while converting or finishing
// oDONE  : one-cycle pulse when oBCD/oBLANK/oOVF update
// oOVF   : last accepted input exceeded 99,999,999
//
// state | meaning
// IDLE  | waiting for iSTART, results held
// CONV  | one add-3/shift iteration per edge, BIN_W iterations total
// DONE  | publish result, blank mask and overflow flag, pulse oDONE
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = bin_to_bcd_pkg::DIGITS
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [BIN_W-1:0]      iBIN,
    input  logic                  iSTART,
    output logic [4*DIGITS-1:0]   oBCD,
    output logic [DIGITS-1:0]     oBLANK,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic                  oOVF
);

    localparam int                BCD_W     = 4 * DIGITS;
    localparam int                CNT_W     = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIN_W - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    state_e              state_q, state_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]    scr_q, scr_d, scr_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d, blank_calc;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    // Per-digit correction; no carry between digits is needed because a
    // corrected digit never exceeds 4'hC before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scr_q[4*g +: 4]),
            .dout (scr_adj[4*g +: 4])
        );
    end

    // Digit i blanks only when it and all higher digits are zero.
    always_comb begin
        logic all_zero;
        blank_calc = '0;
        all_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero & (scr_q[4*i +: 4] == 4'd0);
            blank_calc[i] = all_zero;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (iSTART) begin
                    bin_d      = iBIN;
                    scr_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (32'(iBIN) > BCD_MAX);
                    state_d    = CONV;
                end
            end
            CONV: begin
                {scr_d, bin_d} = {scr_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Out-of-range scratch contents are meaningless, so saturate.
                bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : scr_q;
                blank_d = ovf_pend_q ? '0 : blank_calc;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= BLANK_RST;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign oBCD   = bcd_q;
    assign oBLANK = blank_q;
    assign oBUSY  = (state_q != IDLE);
    assign oDONE  = done_q;
    assign oOVF   = ovf_q;

endmodule
